// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_t;

   typedef logic [DIGIT_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX      = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   // Clamp a digit that the upstream adder may leave above 9.
   function automatic bcd_t sat_digit(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   function automatic logic [7:0] sanitize(input logic [7:0] b);
      return {sat_digit(b[7:4]), sat_digit(b[3:0])};
   endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: counts enabled cycles and flags the last one of each TICK_DIV period.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] count;

   // Combinational so the decrement lands on the same edge the count wraps.
   assign tick = enable && (count == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown stage: loads BCD minutes from the adder and counts down to 00:00.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] preset,
   input  logic       start,
   input  logic       clear,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   state_t     state;
   logic       tick;
   logic       pre_clr;
   logic [7:0] san_preset;
   bcd_t       n_s1, n_s10, n_m1, n_m10;
   logic       dec_zero;

   assign san_preset = sanitize(preset);
   assign pre_clr    = clear || (state == IDLE) || (state == DONE);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state == RUN),
      .clear  (pre_clr),
      .tick   (tick)
   );

   // One-second BCD borrow chain; never evaluated at 00:00 while running.
   always_comb begin
      n_s1  = sec_bcd[3:0];
      n_s10 = sec_bcd[7:4];
      n_m1  = min_bcd[3:0];
      n_m10 = min_bcd[7:4];
      if (sec_bcd[3:0] != 4'd0) begin
         n_s1 = sec_bcd[3:0] - 4'd1;
      end else begin
         n_s1 = BCD_MAX;
         if (sec_bcd[7:4] != 4'd0) begin
            n_s10 = sec_bcd[7:4] - 4'd1;
         end else begin
            n_s10 = SEC_TENS_MAX;
            if (min_bcd[3:0] != 4'd0) begin
               n_m1 = min_bcd[3:0] - 4'd1;
            end else begin
               n_m1 = BCD_MAX;
               if (min_bcd[7:4] != 4'd0) n_m10 = min_bcd[7:4] - 4'd1;
            end
         end
      end
   end

   assign dec_zero = ({n_m10, n_m1, n_s10, n_s1} == 16'h0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         min_bcd <= 8'h00;
         sec_bcd <= 8'h00;
         running <= 1'b0;
         done    <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               min_bcd <= san_preset;
               sec_bcd <= 8'h00;
               if (!clear && start && (san_preset != 8'h00)) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (clear) begin
                  state   <= IDLE;
                  running <= 1'b0;
                  min_bcd <= san_preset;
                  sec_bcd <= 8'h00;
               end else if (tick && dec_zero) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                  alarm   <= 1'b1;
                  min_bcd <= 8'h00;
                  sec_bcd <= 8'h00;
               end else begin
                  if (tick) begin
                     min_bcd <= {n_m10, n_m1};
                     sec_bcd <= {n_s10, n_s1};
                  end
                  if (start) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end
               end
            end
            PAUSE: begin
               if (clear) begin
                  state   <= IDLE;
                  min_bcd <= san_preset;
                  sec_bcd <= 8'h00;
               end else if (start) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            DONE: begin
               if (clear || start) begin
                  state   <= IDLE;
                  alarm   <= 1'b0;
                  min_bcd <= san_preset;
                  sec_bcd <= 8'h00;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a queue-based expected-value scoreboard.
module tb_countdown_timer;

   localparam int unsigned TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] preset;
   logic       start;
   logic       clear;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       done;
   logic       alarm;

   typedef struct packed {
      logic [7:0] min;
      logic [7:0] sec;
      logic       running;
      logic       done;
      logic       alarm;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    compared   = 0;
   int    mismatched = 0;

   countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .preset  (preset),
      .start   (start),
      .clear   (clear),
      .min_bcd (min_bcd),
      .sec_bcd (sec_bcd),
      .running (running),
      .done    (done),
      .alarm   (alarm)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of run, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic expect_push(input string tag, input logic [7:0] m, input logic [7:0] s,
                              input logic r, input logic d, input logic a);
      obs_t e;
      e = '{min: m, sec: s, running: r, done: d, alarm: a};
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_pop();
      obs_t  e;
      obs_t  o;
      string t;
      o = '{min: min_bcd, sec: sec_bcd, running: running, done: done, alarm: alarm};
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard: observed output with no expected entry queued");
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed min=%h sec=%h run=%b done=%b alarm=%b, expected min=%h sec=%h run=%b done=%b alarm=%b",
                   t, o.min, o.sec, o.running, o.done, o.alarm,
                   e.min, e.sec, e.running, e.done, e.alarm);
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      preset = 8'h02;
      start  = 1'b0;
      clear  = 1'b0;

      // Reset values
      expect_push("reset", 8'h00, 8'h00, 0, 0, 0);
      step(2);
      check_pop();
      rst_n = 1'b1;

      // 1: full two-minute run
      expect_push("idle_preset02", 8'h02, 8'h00, 0, 0, 0);
      step(1);
      check_pop();
      expect_push("start_running", 8'h02, 8'h00, 1, 0, 0);
      pulse_start();
      check_pop();
      expect_push("before_first_tick", 8'h02, 8'h00, 1, 0, 0);
      step(3);
      check_pop();
      expect_push("first_tick", 8'h01, 8'h59, 1, 0, 0);
      step(1);
      check_pop();
      expect_push("last_second", 8'h00, 8'h01, 1, 0, 0);
      step(475);
      check_pop();
      expect_push("reach_zero", 8'h00, 8'h00, 0, 1, 1);
      step(1);
      check_pop();
      expect_push("done_one_cycle", 8'h00, 8'h00, 0, 0, 1);
      step(1);
      check_pop();
      expect_push("done_start_idle", 8'h02, 8'h00, 0, 0, 0);
      pulse_start();
      check_pop();

      // 2: borrow through every digit
      preset = 8'h10;
      step(1);
      pulse_start();
      expect_push("borrow_chain", 8'h09, 8'h59, 1, 0, 0);
      step(4);
      check_pop();
      expect_push("clear_from_run", 8'h10, 8'h00, 0, 0, 0);
      pulse_clear();
      check_pop();

      // 3: pause/resume keeps the prescaler phase
      preset = 8'h01;
      step(1);
      pulse_start();
      step(1);
      expect_push("pause_enter", 8'h01, 8'h00, 0, 0, 0);
      pulse_start();
      check_pop();
      expect_push("pause_hold", 8'h01, 8'h00, 0, 0, 0);
      step(19);
      check_pop();
      expect_push("resume", 8'h01, 8'h00, 1, 0, 0);
      pulse_start();
      check_pop();
      expect_push("resume_plus1", 8'h01, 8'h00, 1, 0, 0);
      step(1);
      check_pop();
      expect_push("resume_plus2_tick", 8'h00, 8'h59, 1, 0, 0);
      step(1);
      check_pop();
      pulse_clear();

      // 4: start+clear together, tick+clear, tick+start
      preset = 8'h05;
      step(1);
      pulse_start();
      step(5);
      start = 1'b1;
      clear = 1'b1;
      expect_push("start_clear_same", 8'h05, 8'h00, 0, 0, 0);
      step(1);
      start = 1'b0;
      clear = 1'b0;
      check_pop();
      preset = 8'h37;
      expect_push("idle_tracks_preset", 8'h37, 8'h00, 0, 0, 0);
      step(1);
      check_pop();
      pulse_start();
      step(3);
      expect_push("tick_with_clear", 8'h37, 8'h00, 0, 0, 0);
      pulse_clear();
      check_pop();
      pulse_start();
      step(3);
      expect_push("tick_with_pause", 8'h36, 8'h59, 0, 0, 0);
      pulse_start();
      check_pop();
      pulse_clear();

      // 5: zero preset ignored, out-of-range digits clamp to 9
      preset = 8'h00;
      step(1);
      expect_push("zero_preset_start", 8'h00, 8'h00, 0, 0, 0);
      pulse_start();
      check_pop();
      expect_push("zero_preset_stays", 8'h00, 8'h00, 0, 0, 0);
      step(4);
      check_pop();
      preset = 8'hAF;
      expect_push("sanitize_display", 8'h99, 8'h00, 0, 0, 0);
      step(1);
      check_pop();
      expect_push("sanitize_load", 8'h99, 8'h00, 1, 0, 0);
      pulse_start();
      check_pop();
      expect_push("sanitize_tick", 8'h98, 8'h59, 1, 0, 0);
      step(4);
      check_pop();
      pulse_clear();

      // 6: asynchronous reset mid-count
      preset = 8'h02;
      step(1);
      pulse_start();
      expect_push("at_01_37", 8'h01, 8'h37, 1, 0, 0);
      step(92);
      check_pop();
      #2;
      rst_n = 1'b0;
      expect_push("async_reset", 8'h00, 8'h00, 0, 0, 0);
      #1;
      check_pop();
      step(1);
      rst_n = 1'b1;
      expect_push("after_reset_idle", 8'h02, 8'h00, 0, 0, 0);
      step(1);
      check_pop();
      expect_push("no_tick_without_start", 8'h02, 8'h00, 0, 0, 0);
      step(8);
      check_pop();
      pulse_start();
      expect_push("fresh_start_tick", 8'h01, 8'h59, 1, 0, 0);
      step(4);
      check_pop();

      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
